// File: rtl/systolic_nbody_pkg.sv
// Shared types, saturation helpers, FSM states and tile arithmetic for the
// systolic n-body tile scheduler.
package systolic_nbody_pkg;

  localparam int unsigned DEF_DW    = 32;
  localparam int unsigned DEF_ACC_W = 40;
  localparam int unsigned WIDE_W    = 128;

  typedef logic signed [DEF_DW-1:0]    pos_t;
  typedef logic signed [DEF_ACC_W-1:0] acc_t;
  typedef logic signed [WIDE_W-1:0]    wide_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_INTEG = 2'd3
  } state_t;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic wide_t sat_wide(input wide_t x, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic wide_t saturate_dw(input wide_t x, input int unsigned dw);
    return sat_wide(x, dw);
  endfunction

  function automatic wide_t saturate_acc(input wide_t x, input int unsigned acc_w);
    return sat_wide(x, acc_w);
  endfunction

  // Upper-triangle tile count for nb blocks per side (diagonal included).
  function automatic int unsigned tile_count(input int unsigned nb);
    return (nb * (nb + 1)) / 2;
  endfunction

endpackage

// File: rtl/systolic_nbody_tag_pipe.sv
// LAT-deep shift register carrying {valid, bi, bj} alongside each issued
// tile so returned forces can be routed to the right accumulators.
module systolic_nbody_tag_pipe #(
  parameter int unsigned LAT = 3,
  parameter int unsigned BW  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [BW-1:0] in_bi,
  input  logic [BW-1:0] in_bj,
  output logic          out_valid,
  output logic [BW-1:0] out_bi,
  output logic [BW-1:0] out_bj
);

  logic [LAT-1:0] vld;
  logic [BW-1:0]  bi_sr [LAT];
  logic [BW-1:0]  bj_sr [LAT];

  // Shift tags one stage per cycle; reset empties the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int unsigned s = 0; s < LAT; s++) begin
        bi_sr[s] <= '0;
        bj_sr[s] <= '0;
      end
    end else begin
      vld[0]   <= in_valid;
      bi_sr[0] <= in_bi;
      bj_sr[0] <= in_bj;
      for (int unsigned s = 1; s < LAT; s++) begin
        vld[s]   <= vld[s-1];
        bi_sr[s] <= bi_sr[s-1];
        bj_sr[s] <= bj_sr[s-1];
      end
    end
  end

  assign out_valid = vld[LAT-1];
  assign out_bi    = bi_sr[LAT-1];
  assign out_bj    = bj_sr[LAT-1];

endmodule

// File: rtl/systolic_nbody_tile_scheduler.sv
// Body store, upper-triangle tile issue, antisymmetric force accumulation
// and one Verlet integration pass per timestep.
module systolic_nbody_tile_scheduler
  import systolic_nbody_pkg::*;
#(
  parameter int unsigned N_BODIES = 4,
  parameter int unsigned P        = 2,
  parameter int unsigned DW       = 32,
  parameter int unsigned FRAC     = 16,
  parameter int unsigned ACC_W    = 40,
  parameter int unsigned LAT      = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [DW-1:0]               kdt2,
  input  logic                        ld_valid,
  input  logic [$clog2(N_BODIES)-1:0] ld_idx,
  input  logic [DW-1:0]               ld_q,
  input  logic [DW-1:0]               ld_m,
  input  logic [$clog2(N_BODIES)-1:0] rd_idx,
  output logic [DW-1:0]               rd_q,
  output logic                        arr_valid,
  output logic [P*DW-1:0]             arr_q_i,
  output logic [P*DW-1:0]             arr_m_i,
  output logic [P*DW-1:0]             arr_q_j,
  output logic [P*DW-1:0]             arr_m_j,
  input  logic [P*DW-1:0]             arr_f_i,
  input  logic [P*DW-1:0]             arr_f_j,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 step_cnt
);

  localparam int unsigned IW  = $clog2(N_BODIES);
  localparam int unsigned NB  = N_BODIES / P;
  localparam int unsigned BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned DCW = $clog2(LAT + 1) > 0 ? $clog2(LAT + 1) : 1;

  localparam logic [BW-1:0]  NB_LAST    = BW'(NB - 1);
  localparam logic [IW-1:0]  BODY_LAST  = IW'(N_BODIES - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(LAT);

  state_t                   state;
  logic signed [DW-1:0]     q_mem  [N_BODIES];
  logic signed [DW-1:0]     qo_mem [N_BODIES];
  logic signed [DW-1:0]     m_mem  [N_BODIES];
  logic signed [ACC_W-1:0]  acc_mem[N_BODIES];
  logic [BW-1:0]            bi_cnt, bj_cnt, iss_bi, iss_bj;
  logic [IW-1:0]            body;
  logic [DCW-1:0]           drain_cnt;
  logic                     tag_valid;
  logic [BW-1:0]            tag_bi, tag_bj;
  wide_t                    term, qn_w;
  logic signed [DW-1:0]     q_new;

  function automatic logic signed [ACC_W-1:0] acc_add(
    input logic signed [ACC_W-1:0] a,
    input logic [DW-1:0]           f
  );
    return ACC_W'(saturate_acc(wide_t'(a) + wide_t'($signed(f)), ACC_W));
  endfunction

  systolic_nbody_tag_pipe #(
    .LAT (LAT),
    .BW  (BW)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (arr_valid),
    .in_bi     (iss_bi),
    .in_bj     (iss_bj),
    .out_valid (tag_valid),
    .out_bi    (tag_bi),
    .out_bj    (tag_bj)
  );

  assign busy = (state != ST_IDLE);
  assign rd_q = (32'(rd_idx) < N_BODIES) ? q_mem[rd_idx] : '0;

  // Verlet update for the body currently being integrated.
  always_comb begin
    term  = (wide_t'($signed(kdt2)) * wide_t'(acc_mem[body])) >>> FRAC;
    qn_w  = (wide_t'(q_mem[body]) <<< 1) - wide_t'(qo_mem[body]) + term;
    q_new = DW'(saturate_dw(qn_w, DW));
  end

  // Control FSM, body storage, operand registers and force accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bi_cnt    <= '0;
      bj_cnt    <= '0;
      iss_bi    <= '0;
      iss_bj    <= '0;
      body      <= '0;
      drain_cnt <= '0;
      arr_valid <= 1'b0;
      arr_q_i   <= '0;
      arr_m_i   <= '0;
      arr_q_j   <= '0;
      arr_m_j   <= '0;
      done      <= 1'b0;
      step_cnt  <= '0;
      for (int unsigned i = 0; i < N_BODIES; i++) begin
        q_mem[i]   <= '0;
        qo_mem[i]  <= '0;
        m_mem[i]   <= '0;
        acc_mem[i] <= '0;
      end
    end else begin
      done <= 1'b0;

      // Mirrored tiles are never issued: f_j stands in for them off-diagonal.
      if (tag_valid) begin
        for (int unsigned k = 0; k < P; k++) begin
          acc_mem[IW'(32'(tag_bi) * P + k)] <=
            acc_add(acc_mem[IW'(32'(tag_bi) * P + k)], arr_f_i[k*DW +: DW]);
          if (tag_bi != tag_bj)
            acc_mem[IW'(32'(tag_bj) * P + k)] <=
              acc_add(acc_mem[IW'(32'(tag_bj) * P + k)], arr_f_j[k*DW +: DW]);
        end
      end

      case (state)
        ST_IDLE: begin
          if (ld_valid && (32'(ld_idx) < N_BODIES)) begin
            q_mem[ld_idx]  <= ld_q;
            qo_mem[ld_idx] <= ld_q;
            m_mem[ld_idx]  <= ld_m;
          end
          if (start) begin
            state  <= ST_ISSUE;
            bi_cnt <= '0;
            bj_cnt <= '0;
            for (int unsigned i = 0; i < N_BODIES; i++) acc_mem[i] <= '0;
          end
        end

        ST_ISSUE: begin
          arr_valid <= 1'b1;
          iss_bi    <= bi_cnt;
          iss_bj    <= bj_cnt;
          for (int unsigned k = 0; k < P; k++) begin
            arr_q_i[k*DW +: DW] <= q_mem[IW'(32'(bi_cnt) * P + k)];
            arr_m_i[k*DW +: DW] <= m_mem[IW'(32'(bi_cnt) * P + k)];
            arr_q_j[k*DW +: DW] <= q_mem[IW'(32'(bj_cnt) * P + k)];
            arr_m_j[k*DW +: DW] <= m_mem[IW'(32'(bj_cnt) * P + k)];
          end
          if (bj_cnt == NB_LAST) begin
            if (bi_cnt == NB_LAST) begin
              state     <= ST_DRAIN;
              drain_cnt <= '0;
            end else begin
              bi_cnt <= bi_cnt + 1'b1;
              bj_cnt <= bi_cnt + 1'b1;
            end
          end else begin
            bj_cnt <= bj_cnt + 1'b1;
          end
        end

        // The operand register delays issue by one cycle behind the state,
        // so the state waits LAT+1 cycles to give LAT idle array cycles.
        ST_DRAIN: begin
          arr_valid <= 1'b0;
          if (drain_cnt == DRAIN_LAST) begin
            state <= ST_INTEG;
            body  <= '0;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end

        ST_INTEG: begin
          qo_mem[body] <= q_mem[body];
          q_mem[body]  <= q_new;
          if (body == BODY_LAST) begin
            state    <= ST_IDLE;
            done     <= 1'b1;
            step_cnt <= step_cnt + 1'b1;
          end else begin
            body <= body + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_nbody_tile_scheduler.sv
// Self-checking bench: behavioural array model, directed vector table,
// randomized timesteps against a reference model, multi-cycle corner cases.
module tb_systolic_nbody_tile_scheduler;

  localparam int N   = 4;
  localparam int P   = 2;
  localparam int LAT = 3;
  localparam int T   = 3;
  localparam int STEP_LAT = 1 + T + LAT + N;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] kdt2 = '0;
  logic        ld_valid = 1'b0;
  logic [1:0]  ld_idx = '0;
  logic [31:0] ld_q = '0;
  logic [31:0] ld_m = '0;
  logic [1:0]  rd_idx = '0;
  logic [31:0] rd_q;
  logic        arr_valid;
  logic [63:0] arr_q_i, arr_m_i, arr_q_j, arr_m_j;
  logic [63:0] arr_f_i = '0;
  logic [63:0] arr_f_j = '0;
  logic        busy, done;
  logic [15:0] step_cnt;

  systolic_nbody_tile_scheduler #(
    .N_BODIES (N),
    .P        (P),
    .DW       (32),
    .FRAC     (16),
    .ACC_W    (40),
    .LAT      (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .kdt2      (kdt2),
    .ld_valid  (ld_valid),
    .ld_idx    (ld_idx),
    .ld_q      (ld_q),
    .ld_m      (ld_m),
    .rd_idx    (rd_idx),
    .rd_q      (rd_q),
    .arr_valid (arr_valid),
    .arr_q_i   (arr_q_i),
    .arr_m_i   (arr_m_i),
    .arr_q_j   (arr_q_j),
    .arr_m_j   (arr_m_j),
    .arr_f_i   (arr_f_i),
    .arr_f_j   (arr_f_j),
    .busy      (busy),
    .done      (done),
    .step_cnt  (step_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_steps = 0;

  // reference model state
  logic signed [31:0] mq[N], mqo[N], mm[N];
  logic signed [31:0] fi_tab[T][P], fj_tab[T][P];
  int tile_bi[T], tile_bj[T];

  typedef struct packed {
    logic [3:0][31:0] q;
    logic [31:0]      kdt;
    logic [31:0]      fi;
    logic [31:0]      fj;
    logic [3:0][31:0] exp_q;
  } vec_t;

  typedef struct packed {
    logic        v;
    logic [63:0] fi;
    logic [63:0] fj;
  } hent_t;

  hent_t hist[LAT+1];
  int    tcount;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [127:0] clamp(input logic signed [127:0] x, input int w);
    logic signed [127:0] hi, lo;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // One timestep at the level of the physics: sum forces over the tile
  // list using antisymmetry, then Verlet with floor-scaled acceleration.
  task automatic model_step(input logic signed [31:0] k);
    logic signed [127:0] acc[N];
    logic signed [127:0] kw, tm, qn;
    kw = k;
    for (int b = 0; b < N; b++) acc[b] = '0;
    for (int t = 0; t < T; t++)
      for (int l = 0; l < P; l++) begin
        acc[tile_bi[t]*P+l] = clamp(acc[tile_bi[t]*P+l] + fi_tab[t][l], 40);
        if (tile_bi[t] != tile_bj[t])
          acc[tile_bj[t]*P+l] = clamp(acc[tile_bj[t]*P+l] + fj_tab[t][l], 40);
      end
    for (int b = 0; b < N; b++) begin
      tm = (kw * acc[b]) >>> 16;
      qn = clamp(2 * mq[b] - mqo[b] + tm, 32);
      mqo[b] = mq[b];
      mq[b]  = qn[31:0];
    end
  endtask

  task automatic load_body(input int idx, input logic [31:0] q, input logic [31:0] m);
    ld_valid = 1'b1;
    ld_idx   = 2'(idx);
    ld_q     = q;
    ld_m     = m;
    tick();
    ld_valid = 1'b0;
    mq[idx]  = q;
    mqo[idx] = q;
    mm[idx]  = m;
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < N; i++) begin
      rd_idx = 2'(i);
      #1;
      check($sformatf("%s rd_q[%0d]", tag, i), rd_q, $unsigned(mq[i]));
    end
  endtask

  task automatic check_mem_const(input string tag, input logic [3:0][31:0] exp);
    for (int i = 0; i < N; i++) begin
      rd_idx = 2'(i);
      #1;
      check($sformatf("%s rd_q[%0d]", tag, i), rd_q, exp[i]);
    end
  endtask

  task automatic set_forces_const(input logic [31:0] fi, input logic [31:0] fj);
    for (int t = 0; t < T; t++)
      for (int l = 0; l < P; l++) begin
        fi_tab[t][l] = fi;
        fj_tab[t][l] = fj;
      end
  endtask

  task automatic set_forces_rand();
    for (int t = 0; t < T; t++)
      for (int l = 0; l < P; l++) begin
        fi_tab[t][l] = $signed($urandom_range(0, 32'h1FFFFF)) - 32'sh100000;
        fj_tab[t][l] = $signed($urandom_range(0, 32'h1FFFFF)) - 32'sh100000;
      end
  endtask

  // Launch one timestep and watch it: tile order/operands, latency, done pulse.
  task automatic run_step(input string tag, input bit inject);
    int n, nvalid, first_v, ndone, lat, extra;
    int bi, bj;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; nvalid = 0; first_v = -1; ndone = 0; lat = -1;
    extra = inject ? 15 : 2;
    while (n < 100 && (lat < 0 || n < lat + extra)) begin
      tick();
      n++;
      if (inject && n == 2) begin
        start = 1'b1; ld_valid = 1'b1; ld_idx = 2'd0; ld_q = 32'h12345678; ld_m = '0;
      end
      if (inject && n == 3) begin
        start = 1'b0; ld_valid = 1'b0;
      end
      if (arr_valid) begin
        if (nvalid == 0) first_v = n;
        if (nvalid < T) begin
          bi = tile_bi[nvalid];
          bj = tile_bj[nvalid];
          check({tag, " arr_q_i"}, arr_q_i, {$unsigned(mq[bi*P+1]), $unsigned(mq[bi*P])});
          check({tag, " arr_m_i"}, arr_m_i, {$unsigned(mm[bi*P+1]), $unsigned(mm[bi*P])});
          check({tag, " arr_q_j"}, arr_q_j, {$unsigned(mq[bj*P+1]), $unsigned(mq[bj*P])});
          check({tag, " arr_m_j"}, arr_m_j, {$unsigned(mm[bj*P+1]), $unsigned(mm[bj*P])});
        end
        nvalid++;
      end
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = n;
          check({tag, " step_cnt"}, step_cnt, 16'(exp_steps + 1));
        end
      end
    end
    exp_steps++;
    check({tag, " latency"}, lat, STEP_LAT);
    check({tag, " first issue"}, first_v, 1);
    check({tag, " tile count"}, nvalid, T);
    check({tag, " done pulses"}, ndone, 1);
    check({tag, " idle after"}, busy, 1'b0);
  endtask

  // Behavioural array: returns the forces chosen for each issued tile
  // exactly LAT cycles after issue, garbage otherwise.
  initial begin
    tcount = 0;
    for (int s = 0; s <= LAT; s++) hist[s] = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        for (int s = 0; s <= LAT; s++) hist[s] = '0;
        tcount = 0;
        arr_f_i = '0;
        arr_f_j = '0;
      end else begin
        for (int s = LAT; s > 0; s--) hist[s] = hist[s-1];
        hist[0] = '0;
        if (arr_valid) begin
          if (tcount < T) begin
            hist[0].v  = 1'b1;
            hist[0].fi = {fi_tab[tcount][1], fi_tab[tcount][0]};
            hist[0].fj = {fj_tab[tcount][1], fj_tab[tcount][0]};
          end
          tcount++;
        end
        if (!busy) tcount = 0;
        if (hist[LAT].v) begin
          arr_f_i = hist[LAT].fi;
          arr_f_j = hist[LAT].fj;
        end else begin
          arr_f_i = {$urandom, $urandom};
          arr_f_j = {$urandom, $urandom};
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[3];
    int t;

    t = 0;
    for (int a = 0; a < N / P; a++)
      for (int b = a; b < N / P; b++) begin
        tile_bi[t] = a;
        tile_bj[t] = b;
        t++;
      end
    for (int i = 0; i < N; i++) begin mq[i] = '0; mqo[i] = '0; mm[i] = '0; end
    set_forces_const('0, '0);

    // {-2,-1,1,2}.0, f_i=+1, f_j=-1 -> acc {2,2,0,0}
    vecs[0].q     = {32'h00020000, 32'h00010000, 32'hFFFF0000, 32'hFFFE0000};
    vecs[0].kdt   = 32'h00010000;
    vecs[0].fi    = 32'h00010000;
    vecs[0].fj    = 32'hFFFF0000;
    vecs[0].exp_q = {32'h00020000, 32'h00010000, 32'h00010000, 32'h00000000};
    // positive clamp of body 3
    vecs[1].q     = {32'h7FFF0000, 32'h0, 32'h0, 32'h0};
    vecs[1].kdt   = 32'h00010000;
    vecs[1].fi    = 32'h00040000;
    vecs[1].fj    = 32'h0;
    vecs[1].exp_q = {32'h7FFFFFFF, 32'h00040000, 32'h00080000, 32'h00080000};
    // negative clamp of body 3
    vecs[2].q     = {32'h80010000, 32'h0, 32'h0, 32'h0};
    vecs[2].kdt   = 32'h00010000;
    vecs[2].fi    = 32'hFFFC0000;
    vecs[2].fj    = 32'h0;
    vecs[2].exp_q = {32'h80000000, 32'hFFFC0000, 32'hFFF80000, 32'hFFF80000};

    // reset state
    repeat (3) tick();
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset arr_valid", arr_valid, 1'b0);
    check("reset step_cnt", step_cnt, 16'd0);
    check_mem("reset");
    rst_n = 1'b1;
    tick();

    // directed vector table
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < N; i++) load_body(i, vecs[v].q[i], 32'h00010000);
      kdt2 = vecs[v].kdt;
      set_forces_const(vecs[v].fi, vecs[v].fj);
      run_step($sformatf("vec%0d", v), 1'b0);
      check_mem_const($sformatf("vec%0d", v), vecs[v].exp_q);
      model_step(kdt2);
    end

    // randomized: reload, then two steps so q_old history matters
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++)
        load_body(i, $signed($urandom_range(0, 32'h1FFFFFF)) - 32'sh1000000, $urandom);
      kdt2 = $urandom_range(0, 32'h20000);
      for (int s = 0; s < 2; s++) begin
        set_forces_rand();
        run_step($sformatf("rnd%0d.%0d", r, s), 1'b0);
        model_step(kdt2);
        check_mem($sformatf("rnd%0d.%0d", r, s));
      end
    end

    // start and load pulsed while busy are ignored
    for (int i = 0; i < N; i++) load_body(i, 32'h00010000 * (i + 1), 32'h00010000);
    kdt2 = 32'h00008000;
    set_forces_rand();
    run_step("busy_ignore", 1'b1);
    model_step(kdt2);
    check_mem("busy_ignore");

    // reset in the middle of tile issue
    for (int i = 0; i < N; i++) load_body(i, 32'h00030000, 32'h00010000);
    set_forces_rand();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre-reset arr_valid", arr_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midreset arr_valid", arr_valid, 1'b0);
    check("midreset busy", busy, 1'b0);
    check("midreset done", done, 1'b0);
    check("midreset step_cnt", step_cnt, 16'd0);
    for (int i = 0; i < N; i++) begin mq[i] = '0; mqo[i] = '0; mm[i] = '0; end
    exp_steps = 0;
    check_mem("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < N; i++)
      load_body(i, $signed($urandom_range(0, 32'h1FFFFFF)) - 32'sh1000000, $urandom);
    kdt2 = 32'h00010000;
    set_forces_rand();
    run_step("post_reset", 1'b0);
    model_step(kdt2);
    check_mem("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
